quad_enc_gen: RTL and testbench

- Quadrature encoder signal generator. It is the transmit-side counterpart of the team's quadrature decoder/counter.
- Drives phA/phB as a 4-phase Gray sequence at a programmable edge interval and direction.
- Two run modes: continuous (gated by en) and burst (exactly N edges, then done).
- Used as a motor/encoder emulator in loopback benches and on-board self-test of the motor-control decoder path.
- Also tracks its own net emitted position for cross-checking against the decoder count.

---
 rtl/enc_pkg.sv | 30 +++
 rtl/quad_phase_step.sv | 27 ++
 rtl/quad_enc_gen.sv | 142 ++++++++++++++
 tb/tb_quad_enc_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types and phase helpers for the quadrature encoder generator.
package enc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONT  = 2'd1,
    BURST = 2'd2
  } state_t;

  // Gray phases as {A,B}, listed in A-leads-B order
  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b10;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b01;

  localparam int MIN_PERIOD = 2;

  function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic dir);
    logic [1:0] nxt;
    nxt = PH0;
    case (phase)
      PH0:     nxt = dir ? PH1 : PH3;
      PH1:     nxt = dir ? PH2 : PH0;
      PH2:     nxt = dir ? PH3 : PH1;
      default: nxt = dir ? PH0 : PH2;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_phase_step.sv
// Two-bit Gray phase register; advances one quadrature step per step pulse.
module quad_phase_step
  import enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              dir,
  output logic              phA,
  output logic              phB,
  output logic signed [1:0] delta
);

  logic [1:0] phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PH0;
    end else if (step) begin
      phase <= next_phase(phase, dir);
    end
  end

  assign {phA, phB} = phase;
  assign delta      = dir ? 2'sb01 : 2'sb11;

endmodule

// File: rtl/quad_enc_gen.sv
// Quadrature encoder emulator: continuous or fixed-length bursts of Gray edges,
// with a running signed count of emitted edges.
//
// state | meaning
// IDLE  | phases held, waiting for start (burst) or en (continuous)
// CONT  | free-running while en=1; dir/period re-sampled at each edge
// BURST | emitting burst_len edges with dir/period latched at start
module quad_enc_gen #(
  parameter int PERIOD_W   = 16,
  parameter int CNT_W      = 16,
  parameter int MIN_PERIOD = enc_pkg::MIN_PERIOD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                start,
  input  logic                abort,
  input  logic                dir,
  input  logic [PERIOD_W-1:0] half_period,
  input  logic [CNT_W-1:0]    burst_len,
  input  logic                clr,
  output logic                phA,
  output logic                phB,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pos
);

  import enc_pkg::*;

  state_t              state;
  logic [PERIOD_W-1:0] timer;
  logic [PERIOD_W-1:0] periodLat;
  logic [PERIOD_W-1:0] effPeriod;
  logic [CNT_W-1:0]    remaining;
  logic                dirLat;
  logic                timerDone;
  logic                stepEdge;
  logic signed [1:0]   delta;

  assign effPeriod = (half_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : half_period;
  assign timerDone = (timer == '0);

  // abort and en-drop both suppress an edge that would land on the same clock
  always_comb begin
    stepEdge = 1'b0;
    case (state)
      CONT:    stepEdge = timerDone && en && !abort;
      BURST:   stepEdge = timerDone && !abort;
      default: stepEdge = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      timer     <= '0;
      periodLat <= '0;
      remaining <= '0;
      dirLat    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (burst_len != '0) begin
              state     <= BURST;
              busy      <= 1'b1;
              dirLat    <= dir;
              periodLat <= effPeriod;
              timer     <= effPeriod - PERIOD_W'(1);
              remaining <= burst_len;
            end else begin
              done <= 1'b1;
            end
          end else if (en) begin
            state     <= CONT;
            busy      <= 1'b1;
            dirLat    <= dir;
            periodLat <= effPeriod;
            timer     <= effPeriod - PERIOD_W'(1);
          end
        end
        CONT: begin
          if (abort || !en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (timerDone) begin
            dirLat    <= dir;
            periodLat <= effPeriod;
            timer     <= effPeriod - PERIOD_W'(1);
          end else begin
            timer <= timer - PERIOD_W'(1);
          end
        end
        BURST: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (timerDone) begin
            remaining <= remaining - CNT_W'(1);
            timer     <= periodLat - PERIOD_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            timer <= timer - PERIOD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
    end else if (clr) begin
      pos <= '0;
    end else if (stepEdge) begin
      pos <= pos + {{(CNT_W-2){delta[1]}}, delta};
    end
  end

  quad_phase_step uStep (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (stepEdge),
    .dir   (dirLat),
    .phA   (phA),
    .phB   (phB),
    .delta (delta)
  );

endmodule

// File: tb/tb_quad_enc_gen.sv
// Bench for quad_enc_gen: directed scenarios plus random traffic against a cycle-accurate reference model.
module tb_quad_enc_gen;

  localparam int PW = 16;
  localparam int CW = 16;
  localparam logic [1:0] SEQ [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  logic          clk = 1'b0;
  logic          rst_n, en, start, abort, dir, clr;
  logic [PW-1:0] half_period;
  logic [CW-1:0] burst_len;
  logic          phA, phB, busy, done;
  logic [CW-1:0] pos;

  quad_enc_gen #(.PERIOD_W(PW), .CNT_W(CW), .MIN_PERIOD(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .abort(abort), .dir(dir),
    .half_period(half_period), .burst_len(burst_len), .clr(clr),
    .phA(phA), .phB(phB), .busy(busy), .done(done), .pos(pos)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: run mode, phase index into SEQ, absolute cycle of next edge
  int     mMode;   // 0 idle, 1 continuous, 2 burst
  int     mIdx, mPos, mP, mLeft;
  bit     mDone, mDir;
  longint cyc, mDue;

  // Loopback decoder model
  logic [1:0] prevPh;
  int         decCnt;
  bit         decDir;

  function automatic int eff(input int hp);
    return (hp < 2) ? 2 : hp;
  endfunction

  function automatic int ph_idx(input logic [1:0] p);
    for (int i = 0; i < 4; i++) if (SEQ[i] == p) return i;
    return 0;
  endfunction

  task automatic model_reset();
    mMode = 0; mIdx = 0; mPos = 0; mDone = 0; mDir = 0; mP = 2; mLeft = 0; mDue = 0;
    prevPh = 2'b00; decCnt = 0; decDir = 0;
  endtask

  task automatic model_clock();
    bit stepNow, stepDir;
    stepNow = 0;
    stepDir = mDir;
    mDone = 0;
    case (mMode)
      0: begin
        if (start) begin
          if (burst_len != 0) begin
            mMode = 2; mDir = dir; mP = eff(int'(half_period)); mLeft = int'(burst_len); mDue = cyc + mP;
          end else begin
            mDone = 1;
          end
        end else if (en) begin
          mMode = 1; mDir = dir; mP = eff(int'(half_period)); mDue = cyc + mP;
        end
      end
      1: begin
        if (abort || !en) mMode = 0;
        else if (cyc == mDue) begin
          stepNow = 1; stepDir = mDir;
          mDir = dir; mP = eff(int'(half_period)); mDue = cyc + mP;
        end
      end
      default: begin
        if (abort) mMode = 0;
        else if (cyc == mDue) begin
          stepNow = 1; stepDir = mDir;
          mLeft--;
          if (mLeft == 0) begin
            mMode = 0; mDone = 1;
          end else begin
            mDue = cyc + mP;
          end
        end
      end
    endcase
    if (stepNow) mIdx = (mIdx + (stepDir ? 1 : 3)) % 4;
    if (clr) mPos = 0;
    else if (stepNow) mPos = (mPos + (stepDir ? 1 : 65535)) % 65536;
  endtask

  task automatic tick();
    logic [1:0] cur;
    @(posedge clk);
    cyc++;
    model_clock();
    #1;
    check_val("phase", {30'd0, phA, phB}, {30'd0, SEQ[mIdx]});
    check_val("busy", {31'd0, busy}, {31'd0, mMode != 0});
    check_val("done", {31'd0, done}, {31'd0, mDone});
    check_val("pos", {16'd0, pos}, {16'd0, CW'(mPos)});
    cur = {phA, phB};
    if (cur != prevPh) begin
      if (ph_idx(cur) == (ph_idx(prevPh) + 1) % 4) begin
        decCnt++; decDir = 1;
      end else begin
        decCnt--; decDir = 0;
      end
      prevPh = cur;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 0; start = 0; abort = 0; dir = 0; clr = 0;
    half_period = 4; burst_len = 0;
    #1;
    model_reset();
    check_val("rst_phase", {30'd0, phA, phB}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_pos", {16'd0, pos}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_idle(input string tag, input int maxCyc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < maxCyc);
    check_val(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic clear_pos();
    clr = 1; tick(); clr = 0;
  endtask

  initial begin
    int n;
    cyc = 0;
    @(negedge clk);
    do_reset();
    tick();

    // Forward burst of 8 at period 4: done lands with the 8th edge, 32 clocks after start
    dir = 1; half_period = 4; burst_len = 8; start = 1;
    tick();
    start = 0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 200);
    check_val("s1_done_cycle", n, 32);
    check_val("s1_pos", {16'd0, pos}, 32'd8);
    check_val("s1_busy", {31'd0, busy}, 32'd0);
    tick();

    // Reverse burst with half_period=0 clamps to 2 clocks
    clear_pos();
    dir = 0; half_period = 0; burst_len = 3; start = 1;
    tick();
    start = 0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 100);
    check_val("s2_done_cycle", n, 6);
    check_val("s2_pos", {16'd0, pos}, 32'h0000FFFD);

    // Continuous run, direction flipped after 5 edges, then stopped
    clear_pos();
    dir = 1; half_period = 3; en = 1;
    n = 0;
    while (pos != CW'(5) && n < 100) begin
      tick();
      n++;
    end
    check_val("s3_reach5", {16'd0, pos}, 32'd5);
    dir = 0;
    repeat (40) tick();
    en = 0;
    repeat (10) tick();
    check_val("s3_pos", {16'd0, pos}, 32'h0000FFFA);

    // Abort a 100-edge burst after edge 10
    clear_pos();
    dir = 1; half_period = 2; burst_len = 100; start = 1;
    tick();
    start = 0;
    n = 0;
    while (pos != CW'(10) && n < 100) begin
      tick();
      n++;
    end
    abort = 1;
    tick();
    abort = 0;
    check_val("s4_busy", {31'd0, busy}, 32'd0);
    repeat (10) tick();
    check_val("s4_pos", {16'd0, pos}, 32'd10);

    // Zero-length burst: done one cycle later, no run
    burst_len = 0; start = 1;
    tick();
    start = 0;
    check_val("s5_done", {31'd0, done}, 32'd1);
    check_val("s5_busy", {31'd0, busy}, 32'd0);
    tick();
    check_val("s5_done_off", {31'd0, done}, 32'd0);

    // clr coincident with an edge wins
    dir = 1; half_period = 2; burst_len = 4; start = 1;
    tick();
    start = 0;
    tick();
    clr = 1;
    tick();
    clr = 0;
    check_val("s5_clr_edge", {16'd0, pos}, 32'd0);
    run_to_idle("s5_idle", 50);
    check_val("s5_pos", {16'd0, pos}, 32'd3);

    // Reset mid-burst: no done after release
    dir = 0; burst_len = 10; start = 1;
    tick();
    start = 0;
    repeat (5) tick();
    do_reset();
    repeat (10) tick();

    // Loopback: 1000 forward edges, decoder model must agree with pos
    dir = 1; half_period = 2; burst_len = 1000; start = 1;
    tick();
    start = 0;
    run_to_idle("s6_idle", 2100);
    check_val("s6_pos", {16'd0, pos}, 32'd1000);
    check_val("s6_dec_cnt", {16'd0, pos}, {16'd0, CW'(decCnt)});
    check_val("s6_dec_dir", {31'd0, decDir}, 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 99) < 4);
      abort = ($urandom_range(0, 99) < 2);
      clr   = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 3) en = ~en;
      if ($urandom_range(0, 99) < 5) dir = ~dir;
      if ($urandom_range(0, 99) < 5) half_period = PW'($urandom_range(0, 5));
      if ($urandom_range(0, 99) < 10) burst_len = CW'($urandom_range(0, 6));
      tick();
    end
    start = 0; abort = 0; clr = 0; en = 0;
    run_to_idle("rand_idle", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
